// File: rtl/prog_loader_if.sv
// Host word stream and memory write port of the boot loader.
// The loader takes the slave side; the host/testbench drives the master side.
interface prog_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int N_MEM  = 2
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic [N_MEM-1:0]  mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport slave  (input  s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
   modport master (output s_valid, s_data, input  s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// Framed boot loader: parses WRITE/BOOT headers from a word stream, writes payload
// into one of N_MEM memories, checks a per-frame sum and releases core reset on BOOT.
module prog_loader #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int N_MEM  = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   prog_loader_if.slave bus,
   output logic         core_rst_n,
   output logic         busy,
   output logic         err,
   output logic [2:0]   err_code
);
   typedef enum logic [2:0] {IDLE, PAYLOAD, TRAILER, DRAIN, BOOTED} state_t;
   localparam logic [3:0] CMD_WRITE = 4'h1;
   localparam logic [3:0] CMD_BOOT  = 4'hF;

   state_t            state, state_nx;
   logic [3:0]        chan;
   logic [ADDR_W-1:0] addr;
   logic [11:0]       remaining;
   logic [DATA_W-1:0] sum;
   logic              wrap_pend;

   logic       hs, chan_ok, err_evt;
   logic [2:0] err_val;
   logic [3:0] h_cmd, h_chan;
   logic [11:0] h_cnt;

   assign hs      = bus.s_valid & bus.s_ready;
   assign h_cmd   = bus.s_data[31:28];
   assign h_chan  = bus.s_data[27:24];
   assign h_cnt   = bus.s_data[23:12];
   assign chan_ok = {1'b0, h_chan} < 5'(N_MEM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (hs) begin
               if (h_cmd == CMD_WRITE) begin
                  if (!chan_ok)            state_nx = DRAIN;
                  else if (h_cnt == 12'd0) state_nx = TRAILER;
                  else                     state_nx = PAYLOAD;
               end else if (h_cmd == CMD_BOOT && !err) begin
                  state_nx = BOOTED;
               end
            end
         PAYLOAD: if (hs && remaining == 12'd1) state_nx = TRAILER;
         TRAILER: if (hs) state_nx = IDLE;
         DRAIN:   if (hs && remaining == 12'd0) state_nx = IDLE;
         default: state_nx = state;
      endcase
   end

   always_comb begin
      bus.s_ready = (state != BOOTED);
      busy        = (state == PAYLOAD) || (state == TRAILER) || (state == DRAIN);
      err_evt     = 1'b0;
      err_val     = 3'd0;
      if (hs) begin
         case (state)
            IDLE:
               if (h_cmd == CMD_WRITE && !chan_ok) begin
                  err_evt = 1'b1; err_val = 3'd2;
               end else if (h_cmd == CMD_BOOT && err) begin
                  err_evt = 1'b1; err_val = 3'd5;
               end else if (h_cmd != CMD_WRITE && h_cmd != CMD_BOOT) begin
                  err_evt = 1'b1; err_val = 3'd1;
               end
            // wrap_pend marks that the previous write was at the top address
            PAYLOAD: if (wrap_pend) begin err_evt = 1'b1; err_val = 3'd4; end
            TRAILER: if (bus.s_data != sum) begin err_evt = 1'b1; err_val = 3'd3; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan          <= '0;
         addr          <= '0;
         remaining     <= '0;
         sum           <= '0;
         wrap_pend     <= 1'b0;
         bus.mem_we    <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         core_rst_n    <= 1'b0;
         err           <= 1'b0;
         err_code      <= 3'd0;
      end else begin
         bus.mem_we <= '0;
         if (err_evt) begin
            err <= 1'b1;
            if (!err) err_code <= err_val;
         end
         if (hs) begin
            case (state)
               IDLE: begin
                  chan      <= h_chan;
                  addr      <= bus.s_data[ADDR_W-1:0];
                  remaining <= h_cnt;
                  sum       <= '0;
                  wrap_pend <= 1'b0;
                  if (h_cmd == CMD_BOOT && !err) core_rst_n <= 1'b1;
               end
               PAYLOAD: begin
                  bus.mem_we    <= N_MEM'(1) << chan;
                  bus.mem_addr  <= addr;
                  bus.mem_wdata <= bus.s_data;
                  sum           <= sum + bus.s_data;
                  addr          <= addr + ADDR_W'(1);
                  remaining     <= remaining - 12'd1;
                  wrap_pend     <= &addr;
               end
               DRAIN: if (remaining != 12'd0) remaining <= remaining - 12'd1;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader against a frame-level reference model.
module tb_prog_loader;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int N_MEM  = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       core_rst_n, busy, err;
   logic [2:0] err_code;

   prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_MEM(N_MEM)) bus ();

   prog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_MEM(N_MEM)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .core_rst_n(core_rst_n), .busy(busy), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]        chan;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int          n_vec = 0;
   int          n_bad = 0;
   wr_t         exp_q[$];
   logic [31:0] fixed_pl[$];
   logic        m_err = 1'b0;
   logic [2:0]  m_code = 3'd0;
   logic        m_booted = 1'b0;
   wr_t         mon_e;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_error(input logic [2:0] code);
      if (!m_err) m_code = code;
      m_err = 1'b1;
   endtask

   task automatic chk_err(input string tag);
      chk({tag, "_err"}, err, m_err);
      chk({tag, "_err_code"}, err_code, m_code);
   endtask

   // Every strobe must match the oldest outstanding expected write
   always @(negedge clk) begin
      if (rst_n && bus.mem_we != '0) begin
         if (exp_q.size() == 0) chk("unexpected_we", bus.mem_we, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("mem_we", bus.mem_we, 64'(1) << mon_e.chan);
            chk("mem_addr", bus.mem_addr, mon_e.addr);
            chk("mem_wdata", bus.mem_wdata, mon_e.data);
         end
      end
   end

   task automatic send_word(input logic [31:0] w, input int max_gap);
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         bus.s_valid = 1'b0;
         @(negedge clk);
      end
      chk("s_ready", bus.s_ready, !m_booted);
      bus.s_valid = 1'b1;
      bus.s_data  = w;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_s_ready", bus.s_ready, 1);
      exp_q.delete();
      m_err = 1'b0; m_code = 3'd0; m_booted = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // tr_mode: 0 = correct sum, 1 = corrupted sum, 2 = tr_val; stop_at >= 0 abandons after that many payload words
   task automatic send_frame(input logic [3:0] cmd, input logic [3:0] chan, input int cnt, input int base,
                             input int tr_mode, input logic [31:0] tr_val, input int max_gap, input int stop_at);
      logic [31:0] w, sum, tr;
      bit ok;
      int a;
      sum = '0;
      send_word({cmd, chan, 12'(cnt), 12'(base)}, max_gap);
      if (cmd != 4'h1) begin
         if (cmd == 4'hF) begin
            if (!m_err) m_booted = 1'b1;
            else        m_error(3'd5);
         end else m_error(3'd1);
         bus.s_valid = 1'b0;
         chk_err("hdr");
         chk("busy_hdr_other", busy, 0);
         chk("core_rst_n_hdr", core_rst_n, m_booted);
         return;
      end
      ok = int'(chan) < N_MEM;
      if (!ok) m_error(3'd2);
      chk_err("hdr");
      chk("busy_hdr", busy, 1);
      for (int i = 0; i < cnt; i++) begin
         if (i == stop_at) begin
            bus.s_valid = 1'b0;
            return;
         end
         w = (fixed_pl.size() != 0) ? fixed_pl.pop_front() : $urandom();
         a = (base + i) % DEPTH;
         if (ok) exp_q.push_back('{chan: chan, addr: ADDR_W'(a), data: w});
         send_word(w, max_gap);
         sum += w;
         if (ok && i > 0 && a == 0) m_error(3'd4);
         chk_err("payload");
         chk("busy_payload", busy, 1);
      end
      tr = (tr_mode == 0) ? sum : (tr_mode == 1) ? (sum ^ (32'h1 << $urandom_range(31, 0))) : tr_val;
      if (ok && tr != sum) m_error(3'd3);
      send_word(tr, max_gap);
      bus.s_valid = 1'b0;
      chk_err("trailer");
      chk("busy_end", busy, 0);
      chk("pending_writes", exp_q.size(), 0);
   endtask

   task automatic load_plan_payload();
      fixed_pl.delete();
      fixed_pl.push_back(32'h00500193);
      fixed_pl.push_back(32'h00200213);
      fixed_pl.push_back(32'h004182B3);
   endtask

   initial begin
      logic [3:0] c, ch;
      int r;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      #1 do_reset();

      // Clean frame into program memory, then the same frame with a zero trailer
      load_plan_payload();
      send_frame(4'h1, 4'h0, 3, 0, 0, 32'h0, 0, -1);
      load_plan_payload();
      send_frame(4'h1, 4'h0, 3, 0, 2, 32'h0, 0, -1);
      do_reset();

      // Bad channel drains, then a valid frame to the data memory
      send_frame(4'h1, 4'h5, 2, 7, 0, 32'h0, 1, -1);
      send_frame(4'h1, 4'h1, 4, 20, 0, 32'h0, 1, -1);
      do_reset();

      // Address wrap, then BOOT refused with the first code held
      send_frame(4'h1, 4'h1, 2, DEPTH - 1, 0, 32'h0, 0, -1);
      send_frame(4'hF, 4'h0, 0, 0, 0, 32'h0, 0, -1);
      repeat (3) @(negedge clk);
      chk("boot_refused_core_rst_n", core_rst_n, 0);
      chk("boot_refused_s_ready", bus.s_ready, 1);
      do_reset();

      // Clean WRITE then BOOT
      send_frame(4'h1, 4'h0, 2, 100, 0, 32'h0, 0, -1);
      send_frame(4'hF, 4'h0, 0, 0, 0, 32'h0, 0, -1);
      repeat (3) @(negedge clk);
      chk("booted_core_rst_n", core_rst_n, 1);
      chk("booted_s_ready", bus.s_ready, 0);
      do_reset();

      // Reset mid-frame with stalls, then a fresh frame
      send_frame(4'h1, 4'h0, 3, 16, 0, 32'h0, 3, 1);
      do_reset();
      send_frame(4'h1, 4'h0, 3, 16, 0, 32'h0, 2, -1);

      for (int f = 0; f < 80; f++) begin
         r = int'($urandom_range(99, 0));
         if (r < 6) begin
            send_frame(4'hF, 4'h0, 0, 0, 0, 32'h0, 1, -1);
         end else if (r < 12) begin
            c = 4'($urandom_range(14, 0));
            if (c == 4'h1) c = 4'h0;
            send_frame(c, 4'($urandom()), int'($urandom_range(4, 0)), int'($urandom_range(4095, 0)), 0, 32'h0, 1, -1);
         end else begin
            ch = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(N_MEM - 1, 0));
            send_frame(4'h1, ch, int'($urandom_range(6, 0)),
                       ($urandom_range(1, 0) == 1) ? DEPTH - 1 - int'($urandom_range(2, 0)) : int'($urandom_range(4095, 0)),
                       ($urandom_range(4, 0) == 0) ? 1 : 0, 32'h0, 2, -1);
         end
         if (m_booted || $urandom_range(9, 0) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
